// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision normalise/round stage.
package fp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_ROUND,
      ST_DONE
   } state_t;

   localparam logic [7:0]  EXP_MAX = 8'hFF;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam int          BIAS    = 127;
   localparam logic signed [9:0] EXP_OVF = 10'(2 * BIAS + 1);

   localparam logic [1:0] SP_NORMAL = 2'b00;
   localparam logic [1:0] SP_INF    = 2'b01;
   localparam logic [1:0] SP_NAN    = 2'b10;
   localparam logic [1:0] SP_RSVD   = 2'b11;

   localparam int CARRY  = 27;
   localparam int HIDDEN = 26;
   localparam int LSB    = 3;
   localparam int G      = 2;
   localparam int R      = 1;
   localparam int S      = 0;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on the 28-bit working mantissa; renormalises a carry
// out of the hidden position by one right shift.
module fp_rne_round
   import fp_pkg::*;
(
   input  logic [27:0]        mant,
   input  logic signed [9:0]  exp,
   output logic [27:0]        rnd_mant,
   output logic signed [9:0]  rnd_exp,
   output logic               inexact
);

   logic        inc;
   logic [24:0] sum;

   always_comb begin
      inexact = mant[G] | mant[R] | mant[S];
      inc     = mant[G] & (mant[R] | mant[S] | mant[LSB]);
      sum     = mant[CARRY:LSB] + {24'd0, inc};
      if (sum[24]) begin
         rnd_mant = {1'b0, sum[24:1], 3'b000};
         rnd_exp  = exp + 10'sd1;
      end else begin
         rnd_mant = {1'b0, sum[23:0], 3'b000};
         rnd_exp  = exp;
      end
   end

endmodule

// File: rtl/fp_norm_round.sv
// Normalise-and-round stage behind the FP adder: iterative left normalisation,
// RNE rounding and IEEE-754 single-precision packing.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a sum; in_ready high
//   ST_SHIFT | carry right-shift, zero detect, or one left shift per cycle
//   ST_ROUND | RNE round, saturate/denormal pack into result register
//   ST_DONE  | out_valid high; result held until out_ready
module fp_norm_round
   import fp_pkg::*;
#(
   parameter int MAX_LSHIFT = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [7:0]  in_exp,
   input  logic [27:0] in_mant,
   input  logic [1:0]  in_special,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [2:0]  out_flags
);

   localparam int CNT_W = $clog2(MAX_LSHIFT + 1);

   state_t                state_q, state_d;
   logic                  sign_q, sign_d;
   logic signed [9:0]     exp_q, exp_d;
   logic [27:0]           mant_q, mant_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [31:0]           result_q, result_d;
   logic [2:0]            flags_q, flags_d;

   logic [27:0]           rnd_mant;
   logic signed [9:0]     rnd_exp;
   logic                  rnd_inexact;

   fp_rne_round u_rnd (
      .mant     (mant_q),
      .exp      (exp_q),
      .rnd_mant (rnd_mant),
      .rnd_exp  (rnd_exp),
      .inexact  (rnd_inexact)
   );

   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      mant_d   = mant_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               sign_d = in_sign;
               exp_d  = (in_exp == 8'h00) ? 10'sd1 : $signed({2'b00, in_exp});
               mant_d = in_mant;
               cnt_d  = CNT_W'(MAX_LSHIFT);
               case (in_special)
                  SP_NORMAL: state_d = ST_SHIFT;
                  SP_INF: begin
                     result_d = {in_sign, EXP_MAX, 23'd0};
                     flags_d  = 3'b000;
                     state_d  = ST_DONE;
                  end
                  SP_NAN, SP_RSVD: begin
                     result_d = QNAN;
                     flags_d  = 3'b000;
                     state_d  = ST_DONE;
                  end
                  default: state_d = ST_SHIFT;
               endcase
            end
         end
         ST_SHIFT: begin
            if (mant_q[CARRY]) begin
               // the bit falling off the bottom folds into sticky
               mant_d  = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
               exp_d   = exp_q + 10'sd1;
               state_d = ST_ROUND;
            end else if (mant_q == 28'd0) begin
               result_d = 32'd0;
               flags_d  = 3'b000;
               state_d  = ST_DONE;
            end else if (mant_q[HIDDEN] || exp_q == 10'sd1 || cnt_q == '0) begin
               state_d = ST_ROUND;
            end else begin
               mant_d = {mant_q[26:0], 1'b0};
               exp_d  = exp_q - 10'sd1;
               cnt_d  = cnt_q - 1'b1;
            end
         end
         ST_ROUND: begin
            mant_d = rnd_mant;
            exp_d  = rnd_exp;
            if (rnd_exp >= EXP_OVF) begin
               result_d = {sign_q, EXP_MAX, 23'd0};
               flags_d  = 3'b101;
            end else if (!rnd_mant[HIDDEN]) begin
               result_d = {sign_q, 8'h00, rnd_mant[25:3]};
               flags_d  = {1'b0, rnd_inexact, rnd_inexact};
            end else begin
               result_d = {sign_q, rnd_exp[7:0], rnd_mant[25:3]};
               flags_d  = {2'b00, rnd_inexact};
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         sign_q   <= 1'b0;
         exp_q    <= 10'sd0;
         mant_q   <= 28'd0;
         cnt_q    <= '0;
         result_q <= 32'd0;
         flags_q  <= 3'b000;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign in_ready   = (state_q == ST_IDLE);
   assign out_valid  = (state_q == ST_DONE);
   assign out_result = result_q;
   assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: directed cases plus random sums checked
// against an exact-arithmetic RNE reference model.
module tb_fp_norm_round;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign = 1'b0;
   logic [7:0]  in_exp = 8'd0;
   logic [27:0] in_mant = 28'd0;
   logic [1:0]  in_special = 2'b00;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [2:0]  out_flags;

   fp_norm_round dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_mant    (in_mant),
      .in_special (in_special),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  fl;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   hold_req = 0;
   bit   seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Exact value is m * 2^(e-153); round that to binary32 with ties-to-even.
   function automatic void model(input logic s, input logic [7:0] ein, input logic [27:0] m,
                                 input logic [1:0] sp, output exp_t r);
      int e, p, lsb, be, k;
      logic [63:0] q, rem, half;
      bit inx;
      r.acc = 0;
      e = (ein == 8'd0) ? 1 : int'(ein);
      if (sp == 2'b01) begin
         r.res = {s, 8'hFF, 23'd0}; r.fl = 3'b000; r.lat = 1; return;
      end
      if (sp != 2'b00) begin
         r.res = 32'h7FC0_0000; r.fl = 3'b000; r.lat = 1; return;
      end
      if (m == 28'd0) begin
         r.res = 32'd0; r.fl = 3'b000; r.lat = 2; return;
      end
      p = 0;
      for (int i = 0; i < 28; i++) if (m[i]) p = i;
      k = (p == 27) ? 0 : (((26 - p) < (e - 1)) ? (26 - p) : (e - 1));
      r.lat = 3 + k;
      lsb = ((p - 23) > (4 - e)) ? (p - 23) : (4 - e);
      inx = 1'b0;
      if (lsb > 0) begin
         q    = {36'd0, m} >> lsb;
         rem  = {36'd0, m} & ((64'd1 << lsb) - 64'd1);
         half = 64'd1 << (lsb - 1);
         inx  = (rem != 64'd0);
         if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      end else begin
         q = {36'd0, m} << (-lsb);
      end
      if (q >= (64'd1 << 24)) begin
         q = q >> 1;
         lsb++;
      end
      if (q >= (64'd1 << 23)) begin
         be = e + lsb - 3;
         if (be >= 255) begin
            r.res = {s, 8'hFF, 23'd0}; r.fl = 3'b101;
         end else begin
            r.res = {s, 8'(be), q[22:0]}; r.fl = {2'b00, inx};
         end
      end else begin
         r.res = {s, 8'h00, q[22:0]}; r.fl = {1'b0, inx, inx};
      end
   endfunction

   task automatic send(input exp_t e, input logic s, input logic [7:0] ex, input logic [27:0] m,
                       input logic [1:0] sp, input bit track);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL accept_timeout: in_ready got 0 expected 1");
         return;
      end
      in_valid   = 1'b1;
      in_sign    = s;
      in_exp     = ex;
      in_mant    = m;
      in_special = sp;
      e.acc      = cyc;
      if (track) sb.push_back(e);
      @(negedge clk);
      in_valid   = 1'b0;
      in_mant    = 28'($urandom);
      in_exp     = 8'($urandom);
      in_special = 2'($urandom);
   endtask

   task automatic dir(input logic s, input logic [7:0] ex, input logic [27:0] m, input logic [1:0] sp,
                      input logic [31:0] res, input logic [2:0] fl, input int lat);
      exp_t e;
      e.res = res; e.fl = fl; e.lat = lat; e.acc = 0;
      send(e, s, ex, m, sp, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL drain_timeout: outstanding results got %0d expected 0", sb.size());
      end
   endtask

   initial begin : monitor
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            out_ready = 1'b0;
            seen      = 1'b0;
         end else begin
            if (hold_req > 0) begin
               out_ready = 1'b0;
               if (out_valid) hold_req--;
            end else begin
               out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_valid) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_out_valid: got 1 expected 0");
               end else begin
                  if (!seen) begin
                     seen = 1'b1;
                     check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                  end
                  check("out_result", out_result, sb[0].res);
                  check("out_flags", 32'(out_flags), 32'(sb[0].fl));
                  check("in_ready_busy", 32'(in_ready), 32'd0);
                  if (out_ready) begin
                     void'(sb.pop_front());
                     seen = 1'b0;
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      exp_t dummy;
      dummy.res = 32'd0; dummy.fl = 3'b000; dummy.lat = 0; dummy.acc = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_result", out_result, 32'd0);
      check("reset_out_flags", 32'(out_flags), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      dir(1'b0, 8'd130, 28'h700_0000, 2'b00, 32'h4160_0000, 3'b000, 3);
      dir(1'b0, 8'd128, 28'hC00_0000, 2'b00, 32'h40C0_0000, 3'b000, 3);
      dir(1'b0, 8'd130, 28'h100_0000, 2'b00, 32'h4000_0000, 3'b000, 5);
      dir(1'b0, 8'd127, 28'h7FF_FFFC, 2'b00, 32'h4000_0000, 3'b001, 3);
      dir(1'b0, 8'd254, 28'h800_0000, 2'b00, 32'h7F80_0000, 3'b101, 3);
      dir(1'b1, 8'd100, 28'h000_0000, 2'b00, 32'h0000_0000, 3'b000, 2);
      dir(1'b0, 8'd77,  28'h123_4567, 2'b10, 32'h7FC0_0000, 3'b000, 1);
      dir(1'b1, 8'd3,   28'h000_0000, 2'b01, 32'hFF80_0000, 3'b000, 1);
      dir(1'b0, 8'd0,   28'h000_0010, 2'b00, 32'h0000_0002, 3'b000, 3);
      dir(1'b0, 8'd0,   28'h000_001C, 2'b00, 32'h0000_0004, 3'b011, 3);
      drain();

      hold_req = 5;
      dir(1'b0, 8'd130, 28'h700_0000, 2'b00, 32'h4160_0000, 3'b000, 3);
      drain();

      send(dummy, 1'b0, 8'd40, 28'h000_0001, 2'b00, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midop_reset_out_valid", 32'(out_valid), 32'd0);
      check("midop_reset_out_result", out_result, 32'd0);
      check("midop_reset_out_flags", 32'(out_flags), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_reset_in_ready", 32'(in_ready), 32'd1);
      check("post_reset_out_valid", 32'(out_valid), 32'd0);

      for (int i = 0; i < 300; i++) begin
         logic        s;
         logic [7:0]  ex;
         logic [27:0] m;
         logic [1:0]  sp;
         exp_t        e;
         s = 1'($urandom);
         case ($urandom_range(0, 4))
            0:       m = 28'($urandom);
            1:       m = 28'($urandom) >> $urandom_range(1, 27);
            2:       m = {2'b01, 26'($urandom)};
            3:       m = {1'b1, 27'($urandom)};
            default: m = 28'($urandom) & 28'h000_003F;
         endcase
         case ($urandom_range(0, 2))
            0:       ex = 8'($urandom);
            1:       ex = 8'($urandom_range(0, 24));
            default: ex = 8'($urandom_range(230, 255));
         endcase
         sp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         model(s, ex, m, sp, e);
         send(e, s, ex, m, sp, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
